// File: rtl/interrupt_request_ctrl.sv
// rtl/interrupt_request_ctrl.sv - debounced, acknowledge-held CPU interrupt request from a pushbutton
// Optional accepted-press counter output enabled by macro INT_CTRL_COUNT_EN.
module interrupt_request_ctrl #(
  parameter int DB_CYCLES = 5,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_INT,
  input  logic       INT_ACK,
  output logic       INT,
  output logic       OVERRUN
`ifdef INT_CTRL_COUNT_EN
  ,
  output logic [7:0] INT_COUNT
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                 s1;
  logic                 s;
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 accept;

  // A press is accepted on the final stable high sample of the press debounce
  assign accept = (state == DB_PRESS) && s && (cnt == CNT_LAST);

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= BTN_INT;
      s  <= s1;
    end
  end

  // Press/release debounce state machine
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s) begin
            state <= DB_PRESS;
            cnt   <= CNT_ONE;
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= DB_RELEASE;
            cnt   <= CNT_ONE;
          end
        end
        DB_RELEASE: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Sticky request flag; a new accept wins over a simultaneous acknowledge
  always_ff @(posedge CLK) begin
    if (RST) begin
      INT     <= 1'b0;
      OVERRUN <= 1'b0;
    end else if (accept) begin
      INT <= 1'b1;
      if (INT && !INT_ACK) begin
        OVERRUN <= 1'b1;
      end
    end else if (INT_ACK) begin
      INT <= 1'b0;
    end
  end

`ifdef INT_CTRL_COUNT_EN
  // Accepted-press counter, wraps naturally at 8 bits
  always_ff @(posedge CLK) begin
    if (RST) begin
      INT_COUNT <= 8'd0;
    end else if (accept) begin
      INT_COUNT <= INT_COUNT + 8'd1;
    end
  end
`endif

endmodule
